// File: rtl/spi_flash_cache_if.sv
// spi_flash_cache_if: CPU read handshake between the core and the flash cache
interface spi_flash_cache_if #(parameter int ADDR_W = 20);
  logic [ADDR_W-1:0] word_address;
  logic rstrb;
  logic [31:0] rdata;
  logic rbusy;
  modport master (output word_address, rstrb, input rdata, rbusy);
  modport slave (input word_address, rstrb, output rdata, rbusy);
endinterface

// File: rtl/spi_flash_cache.sv
// spi_flash_cache: direct-mapped line cache in front of a SPI flash READ (0x03) port
module spi_flash_cache #(
  parameter int ADDR_W = 20,
  parameter int LINES = 16,
  parameter int LINE_WORDS = 4,
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  spi_flash_cache_if.slave bus,
  input  logic invalidate,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic SPI_CLK,
  output logic SPI_CS_N,
  output logic SPI_MOSI,
  input  logic SPI_MISO
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int MW = $clog2(LINES * LINE_WORDS);
  localparam int TW = ADDR_W - MW;
  localparam int NB = 32 + 32 * LINE_WORDS;
  localparam int BW = $clog2(NB);
  localparam int DW = $clog2(2 * CLK_DIV);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, nxt;
  logic [31:0] mem [LINES*LINE_WORDS];
  logic [TW-1:0] tags [LINES];
  logic [LINES-1:0] valid;
  logic [ADDR_W-1:0] a, addr;
  logic [31:0] sr;
  logic [DW-1:0] dcnt;
  logic [BW-1:0] bcnt, d;
  logic pend, hit, bit_end, sample;
  logic [MW-1:0] wr_ix;
  assign a = bus.word_address;
  assign hit = valid[a[MW-1:OW]] && tags[a[MW-1:OW]] == a[ADDR_W-1:MW];
  assign bit_end = dcnt == DW'(2 * CLK_DIV - 1);
  assign sample = dcnt == DW'(CLK_DIV) && bcnt >= BW'(32);
  assign d = bcnt - BW'(32);
  // data bit d lands in line word d/32, little-endian bytes, MSB-first within each byte
  assign wr_ix = MW'(addr & ~ADDR_W'(LINE_WORDS - 1)) + MW'(d >> 5);
  always_ff @(posedge clk)
    state <= resetn ? nxt : IDLE;
  always_comb
    nxt = state == IDLE ? (bus.rstrb && !hit ? FILL : IDLE)
        : state == FILL ? (bit_end && bcnt == BW'(NB - 1) ? DONE : FILL)
        : IDLE;
  always_comb begin
    bus.rbusy = state != IDLE;
    SPI_CS_N = state != FILL;
    SPI_CLK = state == FILL && dcnt >= DW'(CLK_DIV);
    SPI_MOSI = state == FILL && sr[31];
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      bus.rdata <= '0;
      hit_count <= '0;
      miss_count <= '0;
      valid <= '0;
      addr <= '0;
      sr <= '0;
      dcnt <= '0;
      bcnt <= '0;
      pend <= 1'b0;
    end else begin
      if (invalidate) valid <= '0;
      if (state == IDLE && bus.rstrb && hit) begin
        bus.rdata <= mem[a[MW-1:0]];
        hit_count <= hit_count + 32'd1;
      end
      if (state == IDLE && bus.rstrb && !hit) begin
        addr <= a;
        sr <= {8'h03, 24'({a & ~ADDR_W'(LINE_WORDS - 1), 2'b00})};
        dcnt <= '0;
        bcnt <= '0;
        pend <= invalidate;
        miss_count <= miss_count + 32'd1;
      end
      if (state == FILL) begin
        pend <= pend | invalidate;
        dcnt <= bit_end ? '0 : dcnt + 1'b1;
        if (bit_end) begin
          bcnt <= bcnt + 1'b1;
          sr <= {sr[30:0], 1'b0};
        end
      end
      // an invalidate seen anywhere in the fill keeps the new line invalid
      if (state == DONE) begin
        valid[addr[MW-1:OW]] <= !(pend || invalidate);
        bus.rdata <= mem[addr[MW-1:0]];
      end
    end
  always_ff @(posedge clk) begin
    if (state == FILL && sample) mem[wr_ix][{d[4:3], ~d[2:0]}] <= SPI_MISO;
    if (state == DONE) tags[addr[MW-1:OW]] <= addr[ADDR_W-1:MW];
  end
endmodule

// File: tb/tb_spi_flash_cache.sv
// tb_spi_flash_cache: scoreboard bench for two cache builds (CLK_DIV 1 and 2) with a SPI flash model
module tb_spi_flash_cache;
  logic clk = 1'b0;
  logic resetn0, resetn1, inv0, inv1;
  logic [1:0] sck, cs_n, mosi, miso;
  logic [31:0] hit0, miss0, hit1, miss1;
  int n_chk = 0, n_pass = 0;
  logic [31:0] sb[$];
  spi_flash_cache_if b0 ();
  spi_flash_cache_if b1 ();
  spi_flash_cache u0 (
    .clk(clk), .resetn(resetn0), .bus(b0), .invalidate(inv0),
    .hit_count(hit0), .miss_count(miss0),
    .SPI_CLK(sck[0]), .SPI_CS_N(cs_n[0]), .SPI_MOSI(mosi[0]), .SPI_MISO(miso[0])
  );
  spi_flash_cache #(.CLK_DIV(2)) u1 (
    .clk(clk), .resetn(resetn1), .bus(b1), .invalidate(inv1),
    .hit_count(hit1), .miss_count(miss1),
    .SPI_CLK(sck[1]), .SPI_CS_N(cs_n[1]), .SPI_MOSI(mosi[1]), .SPI_MISO(miso[1])
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] fbyte(input logic [23:0] x);
    return x[7:0] ^ x[15:8] ^ x[23:16];
  endfunction
  function automatic logic [31:0] fword(input logic [19:0] w);
    logic [23:0] x;
    x = {2'b00, w, 2'b00};
    return {fbyte(x + 24'd3), fbyte(x + 24'd2), fbyte(x + 24'd1), fbyte(x)};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : fl
    int n;
    logic [31:0] hdr;
    logic [7:0] fb;
    logic m = 1'b0;
    assign miso[g] = m;
    always @(posedge sck[g] or negedge cs_n[g])
      if (!sck[g]) n = 0;
      else begin
        if (n < 32) hdr = {hdr[30:0], mosi[g]};
        n++;
      end
    always @(negedge sck[g])
      if (n >= 32) begin
        fb = fbyte(hdr[23:0] + 24'((n - 32) / 8));
        m = fb[7 - (n - 32) % 8];
      end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic rd(input bit u, input logic [19:0] a, input int inv_at, output int busy, output logic cs_seen);
    @(negedge clk);
    if (u) begin b1.word_address = a; b1.rstrb = 1'b1; end
    else begin b0.word_address = a; b0.rstrb = 1'b1; inv0 = inv_at == 0; end
    sb.push_back(fword(a));
    @(negedge clk);
    b0.rstrb = 1'b0;
    b1.rstrb = 1'b0;
    cs_seen = cs_n[u];
    busy = 0;
    while ((u ? b1.rbusy : b0.rbusy) && busy < 5000) begin
      busy++;
      inv0 = busy == inv_at;
      @(negedge clk);
    end
    inv0 = 1'b0;
    check("busy_bound", 32'(busy < 5000), 32'd1);
    check("rdata", u ? b1.rdata : b0.rdata, sb.size() > 0 ? sb.pop_front() : 32'hDEADBEEF);
  endtask
  initial begin
    int busy;
    logic cs;
    logic [15:0] sh;
    resetn0 = 1'b0; resetn1 = 1'b0; inv0 = 1'b0; inv1 = 1'b0;
    b0.rstrb = 1'b0; b1.rstrb = 1'b0; b0.word_address = '0; b1.word_address = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", b0.rdata, 32'd0);
    check("rst_rbusy", 32'(b0.rbusy), 32'd0);
    check("rst_pins", {29'd0, cs_n[0], sck[0], mosi[0]}, 32'b100);
    check("rst_hits", hit0, 32'd0);
    check("rst_misses", miss0, 32'd0);
    resetn0 = 1'b1; resetn1 = 1'b1;
    rd(0, 20'h00000, -1, busy, cs);
    check("miss0_busy", 32'(busy), 32'd321);
    check("miss0_cs", 32'(cs), 32'd0);
    check("miss0_count", miss0, 32'd1);
    check("miss0_hdr", fl[0].hdr, 32'h03000000);
    rd(0, 20'h00003, -1, busy, cs);
    check("hit_busy", 32'(busy), 32'd0);
    check("hit_count", hit0, 32'd1);
    rd(0, 20'h00040, -1, busy, cs);
    check("conflict_busy", 32'(busy), 32'd321);
    check("conflict_hdr", fl[0].hdr, 32'h03000100);
    rd(0, 20'h00000, -1, busy, cs);
    check("refill_busy", 32'(busy), 32'd321);
    check("refill_misses", miss0, 32'd3);
    rd(0, 20'h00001, 0, busy, cs);
    check("inv_hit_busy", 32'(busy), 32'd0);
    check("inv_hit_count", hit0, 32'd2);
    rd(0, 20'h00003, -1, busy, cs);
    check("post_inv_busy", 32'(busy), 32'd321);
    check("post_inv_misses", miss0, 32'd4);
    check("post_inv_cs", 32'(cs), 32'd0);
    check("post_inv_hdr", fl[0].hdr, 32'h03000000);
    @(negedge clk);
    b0.word_address = 20'h00080; b0.rstrb = 1'b1;
    @(negedge clk);
    b0.rstrb = 1'b0;
    repeat (100) @(negedge clk);
    resetn0 = 1'b0;
    @(negedge clk);
    check("abort_cs", 32'(cs_n[0]), 32'd1);
    check("abort_rbusy", 32'(b0.rbusy), 32'd0);
    check("abort_misses", miss0, 32'd0);
    resetn0 = 1'b1;
    rd(0, 20'h00080, -1, busy, cs);
    check("reread_busy", 32'(busy), 32'd321);
    check("reread_misses", miss0, 32'd1);
    rd(0, 20'h00100, 100, busy, cs);
    check("inv_fill_busy", 32'(busy), 32'd321);
    rd(0, 20'h00100, -1, busy, cs);
    check("inv_fill_rebusy", 32'(busy), 32'd321);
    check("inv_fill_misses", miss0, 32'd3);
    @(negedge clk);
    b1.word_address = 20'h00000; b1.rstrb = 1'b1;
    sb.push_back(fword(20'h00000));
    @(negedge clk);
    b1.rstrb = 1'b0;
    busy = 0;
    sh = '0;
    while (b1.rbusy && busy < 5000) begin
      if (busy < 16) sh[busy] = sck[1];
      b1.rstrb = busy == 50;
      if (busy == 50) b1.word_address = 20'h00003;
      busy++;
      @(negedge clk);
    end
    b1.rstrb = 1'b0;
    check("div2_busy", 32'(busy), 32'd641);
    check("div2_sck", 32'(sh), 32'h0000CCCC);
    check("div2_rdata", b1.rdata, sb.size() > 0 ? sb.pop_front() : 32'hDEADBEEF);
    check("div2_misses", miss1, 32'd1);
    check("div2_hits", hit1, 32'd0);
    rd(1, 20'h00003, -1, busy, cs);
    check("div2_hit_busy", 32'(busy), 32'd0);
    check("div2_hit_count", hit1, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
